// File: rtl/decomp_pkg.sv
// decomp_pkg: shared widths, tag/state enums and tag byte-size helper for the block decompressor
package decomp_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA = 8;
  localparam int TAG_WIDTH = 2;
  localparam int LEN_WIDTH = 8;
  localparam int CPR_WIDTH = DATA_WIDTH * NUM_DATA;
  localparam int TAGS_WIDTH = TAG_WIDTH * NUM_DATA;
  localparam int ENTRY_WIDTH = TAGS_WIDTH + CPR_WIDTH + LEN_WIDTH;
  typedef enum logic [1:0] {TAG_ZERO = 2'b00, TAG_BYTE = 2'b01, TAG_HALF = 2'b10, TAG_FULL = 2'b11} tag_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  function automatic logic [5:0] tag_bytes(input tag_t t);
    return t == TAG_FULL ? 6'd4 : t == TAG_HALF ? 6'd2 : t == TAG_BYTE ? 6'd1 : 6'd0;
  endfunction
endpackage

// File: rtl/word_expander.sv
// word_expander: tag + 32-bit window at cursor -> word (zero, sign-extended byte/half, or full)
module word_expander
  import decomp_pkg::*;
(
  input  tag_t                  tag,
  input  logic [DATA_WIDTH-1:0] window,
  output logic [DATA_WIDTH-1:0] word
);
  always_comb
    word = tag == TAG_FULL ? window :
           tag == TAG_HALF ? {{16{window[15]}}, window[15:0]} :
           tag == TAG_BYTE ? {{24{window[7]}}, window[7:0]} : '0;
endmodule

// File: rtl/eight_data_decompress_unit.sv
// eight_data_decompress_unit: pops {tag,cpr_data,len} FIFO entries (clk,reset,in_empty,in_data,pop), expands 8 words one per cycle, presents data_out on out_valid/out_ready with busy and len_err (len check under DECOMP_LEN_CHECK_EN)
module eight_data_decompress_unit
  import decomp_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_empty,
  input  logic [ENTRY_WIDTH-1:0] in_data,
  output logic                   pop,
  output logic [CPR_WIDTH-1:0]   data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   len_err
);
  state_t state;
  logic [TAGS_WIDTH-1:0] tag_r;
  logic [CPR_WIDTH-1:0] cpr_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [5:0] cursor;
  logic [5:0] cursor_nx;
  logic [2:0] idx;
  tag_t cur_tag;
  logic [DATA_WIDTH-1:0] window;
  logic [DATA_WIDTH-1:0] word;
  assign cur_tag = tag_t'(tag_r[{idx, 1'b0} +: TAG_WIDTH]);
  assign window = DATA_WIDTH'(cpr_r >> {cursor, 3'b000});
  assign cursor_nx = cursor + tag_bytes(cur_tag);
  assign pop = state == IDLE && !in_empty && !reset;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  word_expander u_exp (.tag(cur_tag), .window(window), .word(word));
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cursor <= '0;
      idx <= '0;
      data_out <= '0;
      tag_r <= '0;
      cpr_r <= '0;
      len_r <= '0;
    end else
      case (state)
        IDLE: if (!in_empty) begin
          tag_r <= in_data[ENTRY_WIDTH-1 -: TAGS_WIDTH];
          cpr_r <= in_data[LEN_WIDTH +: CPR_WIDTH];
          len_r <= in_data[LEN_WIDTH-1:0];
          cursor <= '0;
          idx <= '0;
          state <= EXPAND;
        end
        EXPAND: begin
          data_out[{idx, 5'b00000} +: DATA_WIDTH] <= word;
          cursor <= cursor_nx;
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef DECOMP_LEN_CHECK_EN
  always_ff @(posedge clk)
    if (reset) len_err <= 1'b0;
    else if (state == EXPAND && idx == 3'd7 && (cursor_nx != len_r[5:0] || len_r[7:6] != 2'b00)) len_err <= 1'b1;
`else
  assign len_err = 1'b0 & (^len_r);
`endif
endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// tb_eight_data_decompress_unit: directed vectors, byte-level expansion model and per-cycle compare process
module tb_eight_data_decompress_unit;
  import decomp_pkg::*;
`ifdef DECOMP_LEN_CHECK_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_empty = 1'b1;
  logic [ENTRY_WIDTH-1:0] in_data = '0;
  logic out_ready = 1'b1;
  logic pop, out_valid, busy, len_err;
  logic [CPR_WIDTH-1:0] data_out;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {logic [255:0] blk; int pc; bit lbad;} exp_t;
  exp_t exq[$];
  logic [279:0] fifo[$];
  bit pop_s;
  bit exp_len_err = 1'b0;
  logic [255:0] prev_d;
  bit prev_hold = 1'b0;

  eight_data_decompress_unit dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data), .pop(pop),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [279:0] e, input int pc);
    exp_t r;
    logic [7:0] by [32];
    logic [15:0] tg;
    logic [255:0] c;
    int pos;
    int n;
    longint v;
    tg = e[279:264];
    c = e[263:8];
    pos = 0;
    for (int b = 0; b < 32; b++) by[b] = c[8*b +: 8];
    r.blk = '0;
    for (int i = 0; i < 8; i++) begin
      n = int'(tg[2*i +: 2]);
      if (n == 3) n = 4;
      v = 0;
      for (int b = 0; b < n; b++) v += longint'(by[pos+b]) << (8*b);
      if (n > 0 && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
      r.blk[32*i +: 32] = v[31:0];
      pos += n;
    end
    r.pc = pc;
    r.lbad = pos != int'(e[7:0]);
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    pop_s = pop;
    @(posedge clk);
    #1;
    if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
    in_empty = fifo.size() == 0;
    in_data = fifo.size() > 0 ? fifo[0] : '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("pop_in_reset", pop, 0);
      exq.delete();
      prev_hold = 1'b0;
      exp_len_err = 1'b0;
    end else begin
      if (pop) chk("pop_when_empty", in_empty, 0);
      if (pop) chk("pop_while_block_held", exq.size(), 0);
      chk("busy", busy, exq.size() != 0);
      chk("out_valid", out_valid, exq.size() > 0 && (cyc - exq[0].pc >= 9));
      if (prev_hold) chk("hold_stable", data_out, prev_d);
      if (out_valid && exq.size() > 0) begin
        chk("data_out", data_out, exq[0].blk);
        if (LE && exq[0].lbad) exp_len_err = 1'b1;
      end
      chk("len_err", len_err, exp_len_err);
      prev_hold = out_valid && !out_ready;
      prev_d = data_out;
      if (out_valid && out_ready && exq.size() > 0) void'(exq.pop_front());
      if (pop && !in_empty) exq.push_back(model(in_data, cyc));
    end
  end

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL %s out_valid timeout got=0 want=1", nm);
    end
  endtask

  task automatic wait_pop(input string nm);
    int n = 0;
    @(negedge clk);
    while (!pop && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!pop) begin
      bad++;
      $display("FAIL %s pop timeout got=0 want=1", nm);
    end
  endtask

  initial begin
    logic [255:0] full_cpr, mixed_cpr, mixed_exp, d0;
    logic [279:0] e_full, e_mixed;
    full_cpr = '0;
    for (int i = 0; i < 8; i++) full_cpr[32*i +: 32] = 32'(i);
    mixed_cpr = '0;
    mixed_cpr[87:0] = 88'h00_FF_01_7F_DE_AD_BE_EF_12_34_80;
    mixed_exp = {32'h0, 32'hFFFFFFFF, 32'h1, 32'h7F, 32'hDEADBEEF, 32'h0, 32'h1234, 32'hFFFFFF80};
    e_full = {16'hFFFF, full_cpr, 8'd32};
    e_mixed = {16'h55C9, mixed_cpr, 8'd11};
    chk("model_mixed_pin", model(e_mixed, 0).blk, mixed_exp);
    chk("model_full_pin", model(e_full, 0).blk, full_cpr);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_data_out", data_out, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    fifo.push_back({16'h0000, {8{32'hA5C3_0F1E}}, 8'd0});
    wait_valid("zero_tags");
    chk("zero_tags_data", data_out, 0);
    chk("zero_tags_len_err", len_err, 0);
    @(posedge clk);
    #1;

    fifo.push_back(e_full);
    wait_valid("full_tags");
    chk("full_tags_data", data_out, full_cpr);
    @(posedge clk);
    #1;

    fifo.push_back(e_mixed);
    wait_valid("mixed_tags");
    chk("mixed_tags_data", data_out, mixed_exp);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    fifo.push_back(e_full);
    fifo.push_back(e_mixed);
    wait_valid("stall_first");
    d0 = data_out;
    repeat (4) begin
      @(negedge clk);
      chk("stall_data_hold", data_out, d0);
      chk("stall_no_pop", pop, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_valid", out_valid, 1);
    chk("handshake_no_pop", pop, 0);
    @(negedge clk);
    chk("pop_after_handshake", pop, 1);
    wait_valid("stall_second");
    chk("stall_second_data", data_out, mixed_exp);
    @(posedge clk);
    #1;

    fifo.push_back({16'hFFFF, full_cpr, 8'd31});
    wait_valid("len31");
    chk("len31_len_err", len_err, LE);
    chk("len31_data", data_out, full_cpr);
    @(posedge clk);
    #1;
    fifo.push_back(e_mixed);
    wait_valid("len_sticky");
    chk("len_err_sticky", len_err, LE);
    @(posedge clk);
    #1;

    fifo.push_back(e_mixed);
    fifo.push_back(e_full);
    wait_pop("abort_pop");
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pop", pop, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_len_err", len_err, 0);
    chk("abort_data_out", data_out, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_valid("after_abort");
    chk("after_abort_data", data_out, full_cpr);
    chk("after_abort_len_err", len_err, 0);
    @(posedge clk);
    #1;
    repeat (5) @(negedge clk);
    chk("fifo_drained", fifo.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
